rs_alu_sched: RTL and testbench

Allocation and issue scheduler for the ALU reservation station. It tracks which ALU RS entries are occupied, steers up to two dispatched instructions per cycle into free entries, and selects the oldest entry whose operands are both valid for issue to the ALU. It sits between the dispatch stage, the array of ALU RS entries (which hold operands, tags and ALU op), and the ALU pipeline.

---
 rtl/rs_alu_sched_pkg.sv | 9 +
 rtl/rs_alu_sched_prio_enc_2.sv | 36 +++
 rtl/rs_alu_sched.sv | 139 +++++++++++++
 tb/tb_rs_alu_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rs_alu_sched_pkg.sv
// rs_alu_sched_pkg: shared constants for the ALU reservation-station scheduler.
//   ALU_ENT_NUM : number of ALU RS entries (power of two, >= 2)
//   ALU_ENT_SEL : log2(ALU_ENT_NUM), width of an entry index
package rs_alu_sched_pkg;

  localparam int unsigned ALU_ENT_NUM = 8;
  localparam int unsigned ALU_ENT_SEL = 3;

endpackage

// File: rtl/rs_alu_sched_prio_enc_2.sv
// prio_enc_2: returns the lowest and second-lowest set bits of a vector.
//   vec    : input vector to search
//   idx0   : index of the lowest set bit ('0 when none)
//   valid0 : at least one bit set
//   idx1   : index of the second-lowest set bit ('0 when fewer than two)
//   valid1 : at least two bits set
module prio_enc_2 import rs_alu_sched_pkg::*; #(
  parameter int unsigned W   = ALU_ENT_NUM,
  parameter int unsigned SEL = ALU_ENT_SEL
) (
  input  logic [W-1:0]   vec,
  output logic [SEL-1:0] idx0,
  output logic           valid0,
  output logic [SEL-1:0] idx1,
  output logic           valid1
);

  always_comb begin
    idx0   = '0;
    idx1   = '0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (vec[i]) begin
        if (!valid0) begin
          idx0   = SEL'(i);
          valid0 = 1'b1;
        end else if (!valid1) begin
          idx1   = SEL'(i);
          valid1 = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rs_alu_sched.sv
// rs_alu_sched: allocation and oldest-first issue scheduler for the ALU RS.
//   clk, reset     : clock, synchronous active-high reset
//   dp_req_i       : dispatch requests {slot1, slot0}; slot1 only with slot0
//   dp_ready_o     : at least two entries free
//   alloc_we_o     : per-entry write enables for this cycle's allocation
//   alloc_idx0_o   : entry chosen for slot 0 (valid even when not writing)
//   alloc_idx1_o   : entry chosen for slot 1 (valid even when not writing)
//   entry_ready_i  : per-entry operands-valid flags
//   issue_valid_o  : an entry is selected for issue
//   issue_idx_o    : oldest ready busy entry
//   issue_stall_i  : ALU cannot accept an issue this cycle
//   kill_i         : flush; empties the station at the edge
//   busy_o         : registered occupancy
//   free_cnt_o     : number of free entries
module rs_alu_sched import rs_alu_sched_pkg::*; #(
  parameter int unsigned ENT_NUM = ALU_ENT_NUM,
  parameter int unsigned ENT_SEL = ALU_ENT_SEL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         dp_req_i,
  output logic               dp_ready_o,
  output logic [ENT_NUM-1:0] alloc_we_o,
  output logic [ENT_SEL-1:0] alloc_idx0_o,
  output logic [ENT_SEL-1:0] alloc_idx1_o,
  input  logic [ENT_NUM-1:0] entry_ready_i,
  output logic               issue_valid_o,
  output logic [ENT_SEL-1:0] issue_idx_o,
  input  logic               issue_stall_i,
  input  logic               kill_i,
  output logic [ENT_NUM-1:0] busy_o,
  output logic [ENT_SEL:0]   free_cnt_o
);

  logic [ENT_NUM-1:0] busy_q;
  logic [ENT_NUM-1:0] busy_d;
  // older_q[i][j] = 1 : entry i is older than entry j (busy entries only)
  logic [ENT_NUM-1:0] older_q [ENT_NUM];
  logic [ENT_NUM-1:0] older_d [ENT_NUM];

  logic [ENT_NUM-1:0] free_vec;
  logic               free_v0;
  logic               free_v1;
  logic               alloc_fire;
  logic               alloc0;
  logic               alloc1;
  logic [ENT_NUM-1:0] cand;
  logic               blocked;
  logic               issue_accept;

  assign busy_o   = busy_q;
  assign free_vec = ~busy_q;

  prio_enc_2 #(
    .W   (ENT_NUM),
    .SEL (ENT_SEL)
  ) u_free_enc (
    .vec    (free_vec),
    .idx0   (alloc_idx0_o),
    .valid0 (free_v0),
    .idx1   (alloc_idx1_o),
    .valid1 (free_v1)
  );

  always_comb begin
    free_cnt_o = '0;
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      free_cnt_o = free_cnt_o + (ENT_SEL+1)'(free_vec[i]);
    end
  end

  // Readiness asks for two free entries regardless of how many are requested.
  assign dp_ready_o = (free_cnt_o >= (ENT_SEL+1)'(2));
  assign alloc_fire = dp_req_i[0] & dp_ready_o & ~kill_i;
  assign alloc0     = alloc_fire & free_v0;
  assign alloc1     = alloc_fire & dp_req_i[1] & free_v1;

  always_comb begin
    alloc_we_o = '0;
    if (alloc0) alloc_we_o[alloc_idx0_o] = 1'b1;
    if (alloc1) alloc_we_o[alloc_idx1_o] = 1'b1;
  end

  // Oldest-first select: a candidate wins when no other candidate is older.
  assign cand = busy_q & entry_ready_i;

  always_comb begin
    issue_idx_o = '0;
    blocked     = 1'b0;
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < ENT_NUM; j++) begin
        if (j != i && cand[j] && older_q[j][i]) blocked = 1'b1;
      end
      if (cand[i] && !blocked) issue_idx_o = ENT_SEL'(i);
    end
  end

  assign issue_valid_o = (|cand) & ~kill_i;
  assign issue_accept  = issue_valid_o & ~issue_stall_i;

  // Allocation only targets free entries and issue only busy ones, so the
  // clear and the set never touch the same bit.
  always_comb begin
    busy_d = busy_q;
    if (issue_accept) busy_d[issue_idx_o] = 1'b0;
    busy_d = busy_d | alloc_we_o;
  end

  // New entries become younger than everything: set the column, then clear
  // the row (which also clears the diagonal). Applying slot 0 before slot 1
  // leaves slot 0 older than slot 1.
  always_comb begin
    older_d = older_q;
    if (alloc0) begin
      for (int unsigned j = 0; j < ENT_NUM; j++) older_d[j][alloc_idx0_o] = 1'b1;
      older_d[alloc_idx0_o] = '0;
    end
    if (alloc1) begin
      for (int unsigned j = 0; j < ENT_NUM; j++) older_d[j][alloc_idx1_o] = 1'b1;
      older_d[alloc_idx1_o] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      for (int unsigned i = 0; i < ENT_NUM; i++) older_q[i] <= '0;
    end else begin
      if (kill_i) begin
        busy_q <= '0;
      end else begin
        busy_q <= busy_d;
      end
      for (int unsigned i = 0; i < ENT_NUM; i++) older_q[i] <= older_d[i];
    end
  end

endmodule

// File: tb/tb_rs_alu_sched.sv
module tb_rs_alu_sched;

  logic       clk;
  logic       reset;
  logic [1:0] dp_req_i;
  logic       dp_ready_o;
  logic [7:0] alloc_we_o;
  logic [2:0] alloc_idx0_o;
  logic [2:0] alloc_idx1_o;
  logic [7:0] entry_ready_i;
  logic       issue_valid_o;
  logic [2:0] issue_idx_o;
  logic       issue_stall_i;
  logic       kill_i;
  logic [7:0] busy_o;
  logic [3:0] free_cnt_o;

  rs_alu_sched #(
    .ENT_NUM (8),
    .ENT_SEL (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .dp_req_i      (dp_req_i),
    .dp_ready_o    (dp_ready_o),
    .alloc_we_o    (alloc_we_o),
    .alloc_idx0_o  (alloc_idx0_o),
    .alloc_idx1_o  (alloc_idx1_o),
    .entry_ready_i (entry_ready_i),
    .issue_valid_o (issue_valid_o),
    .issue_idx_o   (issue_idx_o),
    .issue_stall_i (issue_stall_i),
    .kill_i        (kill_i),
    .busy_o        (busy_o),
    .free_cnt_o    (free_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: occupancy bitmap plus a queue of busy entries, oldest first.
  bit [7:0] m_busy;
  int       age_q[$];

  // Decisions computed in drive(), applied to the model at the next edge.
  bit p_fire, p_dual, p_accept, p_kill;
  int p_f0, p_f1, p_iss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit [1:0] req, input bit [7:0] rdy, input bit st, input bit kl);
    int free, f0, f1, iss;
    bit exp_ready, fire, exp_iv;
    bit [7:0] exp_we;
    dp_req_i      = req;
    entry_ready_i = rdy;
    issue_stall_i = st;
    kill_i        = kl;
    #1;
    free = 0; f0 = -1; f1 = -1;
    for (int i = 0; i < 8; i++) begin
      if (!m_busy[i]) begin
        free++;
        if (f0 < 0) f0 = i;
        else if (f1 < 0) f1 = i;
      end
    end
    exp_ready = (free >= 2);
    fire      = req[0] && exp_ready && !kl;
    exp_we    = '0;
    if (fire) begin
      exp_we[f0] = 1'b1;
      if (req[1]) exp_we[f1] = 1'b1;
    end
    iss = -1;
    foreach (age_q[k]) if (iss < 0 && rdy[age_q[k]]) iss = age_q[k];
    exp_iv = (iss >= 0) && !kl;

    chk("free_cnt", 32'(free_cnt_o), 32'(free));
    chk("dp_ready", 32'(dp_ready_o), 32'(exp_ready));
    chk("alloc_we", 32'(alloc_we_o), 32'(exp_we));
    if (free >= 1) chk("alloc_idx0", 32'(alloc_idx0_o), 32'(f0));
    if (free >= 2) chk("alloc_idx1", 32'(alloc_idx1_o), 32'(f1));
    chk("issue_valid", 32'(issue_valid_o), 32'(exp_iv));
    if (exp_iv) chk("issue_idx", 32'(issue_idx_o), 32'(iss));

    p_fire = fire; p_dual = fire && req[1]; p_kill = kl;
    p_accept = exp_iv && !st;
    p_f0 = f0; p_f1 = f1; p_iss = iss;
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset || p_kill) begin
      m_busy = '0;
      age_q.delete();
    end else begin
      if (p_accept) begin
        m_busy[p_iss] = 1'b0;
        foreach (age_q[k]) if (age_q[k] == p_iss) begin age_q.delete(k); break; end
      end
      if (p_fire) begin
        m_busy[p_f0] = 1'b1;
        age_q.push_back(p_f0);
        if (p_dual) begin
          m_busy[p_f1] = 1'b1;
          age_q.push_back(p_f1);
        end
      end
    end
    p_fire = 0; p_dual = 0; p_accept = 0; p_kill = 0;
    #1;
    chk("busy", 32'(busy_o), 32'(m_busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int ord[4];
    bit [1:0] rq;
    reset = 1'b1;
    dp_req_i = '0; entry_ready_i = '0; issue_stall_i = 1'b0; kill_i = 1'b0;
    m_busy = '0; age_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_free", 32'(free_cnt_o), 32'd8);
    chk("rst_ready", 32'(dp_ready_o), 32'd1);
    chk("rst_iv", 32'(issue_valid_o), 32'd0);
    chk("rst_we", 32'(alloc_we_o), 32'h0);

    // Dual dispatch, oldest-first issue
    drive(2'b11, 8'h00, 0, 0);
    chk("dual_we", 32'(alloc_we_o), 32'h03);
    chk("dual_idx0", 32'(alloc_idx0_o), 32'd0);
    chk("dual_idx1", 32'(alloc_idx1_o), 32'd1);
    tick();
    drive(2'b00, 8'h03, 0, 0);
    chk("dual_iss_a", 32'(issue_idx_o), 32'd0);
    tick();
    drive(2'b00, 8'h03, 0, 0);
    chk("dual_iss_b", 32'(issue_idx_o), 32'd1);
    tick();

    // Stall holds entry 2
    drive(2'b11, 8'h00, 0, 0); tick();
    drive(2'b01, 8'h00, 0, 0); tick();
    for (int c = 0; c < 3; c++) begin
      drive(2'b00, 8'h04, 1, 0);
      chk("stall_iv", 32'(issue_valid_o), 32'd1);
      chk("stall_idx", 32'(issue_idx_o), 32'd2);
      tick();
      chk("stall_busy2", 32'(busy_o[2]), 32'd1);
    end
    drive(2'b00, 8'h04, 0, 0); tick();
    chk("release_busy2", 32'(busy_o[2]), 32'd0);
    drive(2'b00, 8'h00, 0, 1); tick();

    // Full: seven entries occupied
    repeat (3) begin drive(2'b11, 8'h00, 0, 0); tick(); end
    drive(2'b01, 8'h00, 0, 0); tick();
    drive(2'b01, 8'h00, 0, 0);
    chk("full_free", 32'(free_cnt_o), 32'd1);
    chk("full_ready", 32'(dp_ready_o), 32'd0);
    chk("full_we", 32'(alloc_we_o), 32'h00);
    tick();
    drive(2'b00, 8'h00, 0, 1); tick();

    // Age versus index
    drive(2'b11, 8'h00, 0, 0); tick();
    drive(2'b11, 8'h00, 0, 0); tick();
    drive(2'b00, 8'h01, 0, 0);
    chk("age_iss0", 32'(issue_idx_o), 32'd0);
    tick();
    drive(2'b01, 8'h00, 0, 0);
    chk("age_realloc_we", 32'(alloc_we_o), 32'h01);
    tick();
    ord = '{1, 2, 3, 0};
    for (int k = 0; k < 4; k++) begin
      drive(2'b00, 8'hFF, 0, 0);
      chk("age_order", 32'(issue_idx_o), 32'(ord[k]));
      tick();
    end

    // Kill collides with dispatch and issue
    drive(2'b01, 8'h00, 0, 0); tick();
    drive(2'b11, 8'h01, 0, 1);
    chk("kill_iv", 32'(issue_valid_o), 32'd0);
    chk("kill_we", 32'(alloc_we_o), 32'h00);
    tick();
    chk("kill_busy", 32'(busy_o), 32'h00);
    chk("kill_free", 32'(free_cnt_o), 32'd8);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 2))
        0:       rq = 2'b00;
        1:       rq = 2'b01;
        default: rq = 2'b11;
      endcase
      if (c == 200) reset = 1'b1;
      drive(rq, 8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
      tick();
      reset = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
